mem_stage_lsu: RTL and testbench
================================

Name: mem_stage_lsu

Overview:
Parametrised load/store memory stage that sits between the execute and writeback stages. It adds byte/halfword/word (and doubleword when XLEN=64) accesses with sign/zero extension and store byte-lane steering. It talks to data memory over a req/ready handshake with a stall output and a bus-timeout counter, and reports misalignment and bus errors. Non-memory instructions pass alu_result through with one cycle of latency.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64.
ADDR_W, 32, address width.
TIMEOUT, 16, maximum cycles in REQ without dmem_ready before a bus error; must be >=1.
BE_W, XLEN/8, number of byte enables (derived).
OFF_W, log2(BE_W), byte-offset bits (derived).

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
in_valid  in  1  instruction present from execute
alu_result  in  XLEN  effective address, or the result for non-memory ops
rs2_data  in  XLEN  store data
rd  in  5  destination register
mem_read  in  1  load
mem_write  in  1  store
funct3  in  3  access size/sign (RISC-V encoding)
stall  out  1  upstream must hold its inputs
dmem_req  out  1  memory request
dmem_we  out  1  write request
dmem_addr  out  ADDR_W  address aligned to XLEN/8
dmem_wdata  out  XLEN  lane-steered store data
dmem_be  out  BE_W  byte enables
dmem_ready  in  1  request completes this cycle; read data valid
dmem_rdata  in  XLEN  read data
out_valid  out  1  one-cycle pulse, result ready
out_rd  out  5  destination register
out_result  out  XLEN  formatted load data or alu_result
out_reg_write  out  1  writeback enable (0 for stores and faults)
out_misaligned  out  1  misaligned or illegal-size fault
out_bus_error  out  1  timeout fault

Behaviour:
- Reset (reset=0, async): state IDLE. All outputs 0, including dmem_req (deasserts immediately) and out_* registers. Timeout counter 0. An in-flight request is dropped with no out_valid.
- FSM states: IDLE, REQ.
- IDLE, in_valid=1, neither mem_read nor mem_write set: next cycle out_valid=1, out_result=alu_result, out_reg_write=1.
- IDLE, memory op: decode the access.
  - Size: funct3[1:0] 00=B, 01=H, 10=W, 11=D. funct3[2]=1 means unsigned (loads only).
  - Illegal if any of: D with XLEN=32; funct3=111; store with funct3[2]=1; load WU (110) with XLEN=32.
  - Misaligned if the address is not size-aligned, i.e. H needs addr[0]=0, W needs addr[1:0]=0, D needs addr[2:0]=0.
  - Illegal or misaligned: no request. Next cycle out_valid=1, out_misaligned=1, out_reg_write=0, out_result=alu_result.
  - Otherwise: latch the operation, go to REQ, counter=0.
- mem_read and mem_write both set: treated as a store.
- REQ:
  - dmem_req=1 and stall=1.
  - dmem_addr = {addr[ADDR_W-1:OFF_W], 0}.
  - dmem_we=1 for stores.
  - dmem_be = size mask << offset.
  - dmem_wdata = low size bytes of rs2 shifted to offset*8.
  - For reads dmem_be=all ones.
  - All dmem_* outputs stay stable until dmem_ready.
- REQ, dmem_ready=1:
  - Load: extract the bytes at offset, then sign- or zero-extend to XLEN per funct3[2].
  - Go to IDLE. Next cycle out_valid=1.
  - out_reg_write = load (1) or store (0).
- REQ, no ready: counter increments. When counter reaches TIMEOUT-1 without ready, abort: go to IDLE, next cycle out_valid=1, out_bus_error=1, out_reg_write=0.
- dmem_ready in the same cycle as the final timeout count: ready wins, and there is no error.
- stall=0 in IDLE. in_valid is ignored while in REQ.
- Load latency with zero-wait memory: in_valid at cycle N, dmem_req at N+1, out_valid at N+2. Each wait cycle adds one.
- out_* registers hold their values between pulses. out_misaligned and out_bus_error are valid only with out_valid.
- dmem_ready seen in IDLE is ignored.

Test Plan:
- XLEN=32, non-mem op, alu_result=0x0000_1234, rd=5 -> one cycle later: out_valid=1, out_result=0x1234, out_rd=5, out_reg_write=1, dmem_req never set.
- LB at 0x103, rdata=0x80FF_0000, ready on first REQ cycle -> dmem_addr=0x100, out_result=0xFFFF_FF80, out_valid at N+2. Repeat as LBU -> out_result=0x0000_0080.
- SH at 0x102, rs2=0xDEAD_BEEF, 3 wait cycles -> dmem_we=1, be=4'b1100, wdata=0xBEEF_0000, stall high 4 cycles, out_valid with out_reg_write=0.
- LW at 0x102 -> no dmem_req, out_misaligned=1, out_reg_write=0. LD (funct3=011) with XLEN=32 -> out_misaligned=1.
- TIMEOUT=4, LW at 0x200, ready never asserted -> req high 4 cycles, then out_bus_error=1. Second run with ready on the 4th cycle -> normal completion, no error.
- reset driven low mid-REQ -> dmem_req=0 and stall=0 immediately, no out_valid. After release, a fresh LW completes normally. XLEN=64 LD at 0x8 -> be=8'hFF, full 64-bit result.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// Load/store memory stage: decodes size/sign, steers store lanes, formats load data,
// and runs a two-state req/ready handshake to data memory with a bus-timeout abort.
module mem_stage_lsu #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int BE_W    = XLEN / 8,
    parameter int OFF_W   = $clog2(XLEN / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   alu_result,
    input  logic [XLEN-1:0]   rs2_data,
    input  logic [4:0]        rd,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    output logic              stall,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] dmem_addr,
    output logic [XLEN-1:0]   dmem_wdata,
    output logic [BE_W-1:0]   dmem_be,
    input  logic              dmem_ready,
    input  logic [XLEN-1:0]   dmem_rdata,
    output logic              out_valid,
    output logic [4:0]        out_rd,
    output logic [XLEN-1:0]   out_result,
    output logic              out_reg_write,
    output logic              out_misaligned,
    output logic              out_bus_error
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {IDLE, REQ} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               is_load_q, is_load_d;
    logic               uns_q, uns_d;
    logic [1:0]         size_q, size_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [4:0]         rd_q, rd_d;
    logic [XLEN-1:0]    alu_q, alu_d;

    logic               dmem_req_q, dmem_req_d;
    logic               dmem_we_q, dmem_we_d;
    logic [ADDR_W-1:0]  dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]    dmem_wdata_q, dmem_wdata_d;
    logic [BE_W-1:0]    dmem_be_q, dmem_be_d;

    logic               out_valid_q, out_valid_d;
    logic [4:0]         out_rd_q, out_rd_d;
    logic [XLEN-1:0]    out_result_q, out_result_d;
    logic               out_reg_write_q, out_reg_write_d;
    logic               out_misaligned_q, out_misaligned_d;
    logic               out_bus_error_q, out_bus_error_d;

    // Access decode for the instruction currently offered by execute.
    logic               is_store;
    logic [1:0]         size;
    logic [OFF_W-1:0]   offset;
    logic               illegal;
    logic               misaligned;
    logic [BE_W-1:0]    size_mask;
    logic [XLEN-1:0]    lane_mask;
    logic [ADDR_W-1:0]  addr_ext;

    always_comb begin
        is_store = mem_write;
        size     = funct3[1:0];
        offset   = alu_result[OFF_W-1:0];
        addr_ext = ADDR_W'(alu_result);

        illegal = (funct3 == 3'b111)
               || (is_store && funct3[2])
               || (XLEN == 32 && size == 2'b11)
               || (XLEN == 32 && funct3 == 3'b110);

        case (size)
            2'd1:    misaligned = alu_result[0];
            2'd2:    misaligned = |alu_result[1:0];
            2'd3:    misaligned = |alu_result[2:0];
            default: misaligned = 1'b0;
        endcase

        for (int i = 0; i < BE_W; i++) begin
            size_mask[i]         = (i < (1 << size));
            lane_mask[i*8 +: 8]  = {8{size_mask[i]}};
        end
    end

    // Load formatting from the latched offset/size/sign of the in-flight access.
    logic [XLEN-1:0]    rshift;
    logic [XLEN-1:0]    load_val;
    logic               sign_bit;
    logic               ext_bit;

    always_comb begin
        rshift = dmem_rdata >> {off_q, 3'b000};
        case (size_q)
            2'd0:    sign_bit = rshift[7];
            2'd1:    sign_bit = rshift[15];
            2'd2:    sign_bit = rshift[31];
            default: sign_bit = rshift[XLEN-1];
        endcase
        ext_bit = sign_bit & ~uns_q;
        for (int i = 0; i < XLEN; i++) begin
            load_val[i] = (i < (8 << size_q)) ? rshift[i] : ext_bit;
        end
    end

    always_comb begin
        // NOTE: every _d starts from its _q (or a pulse default) so no path leaves a
        // signal unassigned and no latch is inferred.
        state_d          = state_q;
        cnt_d            = cnt_q;
        is_load_d        = is_load_q;
        uns_d            = uns_q;
        size_d           = size_q;
        off_d            = off_q;
        rd_d             = rd_q;
        alu_d            = alu_q;
        dmem_req_d       = dmem_req_q;
        dmem_we_d        = dmem_we_q;
        dmem_addr_d      = dmem_addr_q;
        dmem_wdata_d     = dmem_wdata_q;
        dmem_be_d        = dmem_be_q;
        out_valid_d      = 1'b0;
        out_rd_d         = out_rd_q;
        out_result_d     = out_result_q;
        out_reg_write_d  = out_reg_write_q;
        out_misaligned_d = out_misaligned_q;
        out_bus_error_d  = out_bus_error_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    if (!mem_read && !mem_write) begin
                        out_valid_d      = 1'b1;
                        out_rd_d         = rd;
                        out_result_d     = alu_result;
                        out_reg_write_d  = 1'b1;
                        out_misaligned_d = 1'b0;
                        out_bus_error_d  = 1'b0;
                    end else if (illegal || misaligned) begin
                        out_valid_d      = 1'b1;
                        out_rd_d         = rd;
                        out_result_d     = alu_result;
                        out_reg_write_d  = 1'b0;
                        out_misaligned_d = 1'b1;
                        out_bus_error_d  = 1'b0;
                    end else begin
                        state_d      = REQ;
                        cnt_d        = '0;
                        is_load_d    = ~is_store;
                        uns_d        = funct3[2];
                        size_d       = size;
                        off_d        = offset;
                        rd_d         = rd;
                        alu_d        = alu_result;
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = is_store;
                        dmem_addr_d  = {addr_ext[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        dmem_be_d    = is_store ? BE_W'(size_mask << offset) : '1;
                        dmem_wdata_d = is_store ? (rs2_data & lane_mask) << {offset, 3'b000} : '0;
                    end
                end
            end

            REQ: begin
                if (dmem_ready || cnt_q == CNT_LAST) begin
                    // A ready on the final count completes normally rather than faulting.
                    state_d          = IDLE;
                    dmem_req_d       = 1'b0;
                    dmem_we_d        = 1'b0;
                    dmem_addr_d      = '0;
                    dmem_wdata_d     = '0;
                    dmem_be_d        = '0;
                    out_valid_d      = 1'b1;
                    out_rd_d         = rd_q;
                    out_result_d     = (dmem_ready && is_load_q) ? load_val : alu_q;
                    out_reg_write_d  = dmem_ready && is_load_q;
                    out_misaligned_d = 1'b0;
                    out_bus_error_d  = ~dmem_ready;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            cnt_q            <= '0;
            is_load_q        <= 1'b0;
            uns_q            <= 1'b0;
            size_q           <= '0;
            off_q            <= '0;
            rd_q             <= '0;
            alu_q            <= '0;
            dmem_req_q       <= 1'b0;
            dmem_we_q        <= 1'b0;
            dmem_addr_q      <= '0;
            dmem_wdata_q     <= '0;
            dmem_be_q        <= '0;
            out_valid_q      <= 1'b0;
            out_rd_q         <= '0;
            out_result_q     <= '0;
            out_reg_write_q  <= 1'b0;
            out_misaligned_q <= 1'b0;
            out_bus_error_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            is_load_q        <= is_load_d;
            uns_q            <= uns_d;
            size_q           <= size_d;
            off_q            <= off_d;
            rd_q             <= rd_d;
            alu_q            <= alu_d;
            dmem_req_q       <= dmem_req_d;
            dmem_we_q        <= dmem_we_d;
            dmem_addr_q      <= dmem_addr_d;
            dmem_wdata_q     <= dmem_wdata_d;
            dmem_be_q        <= dmem_be_d;
            out_valid_q      <= out_valid_d;
            out_rd_q         <= out_rd_d;
            out_result_q     <= out_result_d;
            out_reg_write_q  <= out_reg_write_d;
            out_misaligned_q <= out_misaligned_d;
            out_bus_error_q  <= out_bus_error_d;
        end
    end

    assign stall          = (state_q == REQ);
    assign dmem_req       = dmem_req_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign dmem_be        = dmem_be_q;
    assign out_valid      = out_valid_q;
    assign out_rd         = out_rd_q;
    assign out_result     = out_result_q;
    assign out_reg_write  = out_reg_write_q;
    assign out_misaligned = out_misaligned_q;
    assign out_bus_error  = out_bus_error_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: a 32-bit instance with TIMEOUT=4 and a 64-bit
// instance share clock and reset; inputs change and outputs are sampled on negedges.
module tb_mem_stage_lsu;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    // 32-bit instance
    logic        in_valid = 0, mem_read = 0, mem_write = 0, dmem_ready = 0;
    logic [31:0] alu_result = 0, rs2_data = 0, dmem_rdata = 0;
    logic [4:0]  rd = 0;
    logic [2:0]  funct3 = 0;
    logic        stall, dmem_req, dmem_we, out_valid, out_reg_write, out_misaligned, out_bus_error;
    logic [31:0] dmem_addr, dmem_wdata, out_result;
    logic [3:0]  dmem_be;
    logic [4:0]  out_rd;

    mem_stage_lsu #(.XLEN(32), .ADDR_W(32), .TIMEOUT(4)) dut32 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .alu_result(alu_result),
        .rs2_data(rs2_data), .rd(rd), .mem_read(mem_read), .mem_write(mem_write),
        .funct3(funct3), .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .out_valid(out_valid),
        .out_rd(out_rd), .out_result(out_result), .out_reg_write(out_reg_write),
        .out_misaligned(out_misaligned), .out_bus_error(out_bus_error)
    );

    // 64-bit instance
    logic        w_in_valid = 0, w_mem_read = 0, w_mem_write = 0, w_dmem_ready = 0;
    logic [63:0] w_alu_result = 0, w_rs2_data = 0, w_dmem_rdata = 0;
    logic [4:0]  w_rd = 0;
    logic [2:0]  w_funct3 = 0;
    logic        w_stall, w_dmem_req, w_dmem_we, w_out_valid, w_out_reg_write;
    logic        w_out_misaligned, w_out_bus_error;
    logic [31:0] w_dmem_addr;
    logic [63:0] w_dmem_wdata, w_out_result;
    logic [7:0]  w_dmem_be;
    logic [4:0]  w_out_rd;

    mem_stage_lsu #(.XLEN(64), .ADDR_W(32), .TIMEOUT(4)) dut64 (
        .clk(clk), .reset(reset), .in_valid(w_in_valid), .alu_result(w_alu_result),
        .rs2_data(w_rs2_data), .rd(w_rd), .mem_read(w_mem_read), .mem_write(w_mem_write),
        .funct3(w_funct3), .stall(w_stall), .dmem_req(w_dmem_req), .dmem_we(w_dmem_we),
        .dmem_addr(w_dmem_addr), .dmem_wdata(w_dmem_wdata), .dmem_be(w_dmem_be),
        .dmem_ready(w_dmem_ready), .dmem_rdata(w_dmem_rdata), .out_valid(w_out_valid),
        .out_rd(w_out_rd), .out_result(w_out_result), .out_reg_write(w_out_reg_write),
        .out_misaligned(w_out_misaligned), .out_bus_error(w_out_bus_error)
    );

    task automatic issue32(input logic [31:0] a, input logic [31:0] d, input logic [4:0] r,
                           input logic mr, input logic mw, input logic [2:0] f3);
        in_valid = 1'b1; alu_result = a; rs2_data = d; rd = r;
        mem_read = mr; mem_write = mw; funct3 = f3;
    endtask

    task automatic idle32();
        in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        tests++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin failed++;
            $display("FAIL rst_req: req=%b stall=%b required 0 0", dmem_req, stall); end
        tests++; if (out_valid !== 1'b0 || out_result !== 32'h0 || out_rd !== 5'd0) begin failed++;
            $display("FAIL rst_out: valid=%b result=%h rd=%0d required 0", out_valid, out_result, out_rd); end
        tests++; if (dmem_be !== 4'h0 || dmem_addr !== 32'h0 || w_dmem_req !== 1'b0) begin failed++;
            $display("FAIL rst_bus: be=%h addr=%h req64=%b required 0", dmem_be, dmem_addr, w_dmem_req); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_passthru();
        issue32(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 3'b010);
        @(negedge clk);
        idle32();
        tests++; if (out_valid !== 1'b1 || out_result !== 32'h1234 || out_rd !== 5'd5) begin failed++;
            $display("FAIL pt_out: valid=%b result=%h rd=%0d required 1 1234 5", out_valid, out_result, out_rd); end
        tests++; if (out_reg_write !== 1'b1 || dmem_req !== 1'b0 || stall !== 1'b0) begin failed++;
            $display("FAIL pt_ctl: rw=%b req=%b stall=%b required 1 0 0", out_reg_write, dmem_req, stall); end
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || out_result !== 32'h1234) begin failed++;
            $display("FAIL pt_hold: valid=%b result=%h required 0 1234", out_valid, out_result); end
    endtask

    task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp);
        issue32(32'h0000_0103, 32'h0, 5'd7, 1'b1, 1'b0, f3);
        @(negedge clk);
        idle32();
        tests++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h100 || dmem_be !== 4'hF || dmem_we !== 1'b0) begin failed++;
            $display("FAIL lb_req: req=%b addr=%h be=%h we=%b required 1 100 f 0", dmem_req, dmem_addr, dmem_be, dmem_we); end
        dmem_ready = 1'b1; dmem_rdata = 32'h80FF_0000;
        @(negedge clk);
        dmem_ready = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_result !== exp || out_reg_write !== 1'b1 || out_rd !== 5'd7) begin failed++;
            $display("FAIL lb_out f3=%0d: valid=%b result=%h rw=%b rd=%0d required 1 %h 1 7", f3, out_valid, out_result, out_reg_write, out_rd, exp); end
        tests++; if (out_misaligned !== 1'b0 || out_bus_error !== 1'b0 || stall !== 1'b0) begin failed++;
            $display("FAIL lb_flags: mis=%b berr=%b stall=%b required 0 0 0", out_misaligned, out_bus_error, stall); end
    endtask

    task automatic test_store_wait();
        int stall_cycles = 0;
        issue32(32'h0000_0102, 32'hDEAD_BEEF, 5'd3, 1'b0, 1'b1, 3'b001);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            idle32();
            if (stall) stall_cycles++;
            if (i == 2) begin
                tests++; if (dmem_we !== 1'b1 || dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEF_0000 || dmem_addr !== 32'h100) begin failed++;
                    $display("FAIL sh_bus: we=%b be=%b wdata=%h addr=%h required 1 1100 beef0000 100", dmem_we, dmem_be, dmem_wdata, dmem_addr); end
            end
            dmem_ready = (i == 3);
        end
        @(negedge clk);
        dmem_ready = 1'b0;
        tests++; if (stall_cycles != 4) begin failed++;
            $display("FAIL sh_stall: %0d cycles, required 4", stall_cycles); end
        tests++; if (out_valid !== 1'b1 || out_reg_write !== 1'b0 || out_bus_error !== 1'b0 || stall !== 1'b0) begin failed++;
            $display("FAIL sh_out: valid=%b rw=%b berr=%b stall=%b required 1 0 0 0", out_valid, out_reg_write, out_bus_error, stall); end
    endtask

    task automatic test_misaligned(input string name, input logic [31:0] a, input logic [2:0] f3,
                                   input logic mw);
        issue32(a, 32'h0, 5'd9, ~mw, mw, f3);
        @(negedge clk);
        idle32();
        tests++; if (dmem_req !== 1'b0 || out_valid !== 1'b1 || out_misaligned !== 1'b1) begin failed++;
            $display("FAIL %s: req=%b valid=%b mis=%b required 0 1 1", name, dmem_req, out_valid, out_misaligned); end
        tests++; if (out_reg_write !== 1'b0 || out_result !== a || out_bus_error !== 1'b0) begin failed++;
            $display("FAIL %s_out: rw=%b result=%h berr=%b required 0 %h 0", name, out_reg_write, out_result, out_bus_error, a); end
        @(negedge clk);
    endtask

    task automatic test_timeout(input logic ready_last);
        int req_cycles = 0;
        logic got = 1'b0;
        issue32(32'h0000_0200, 32'h0, 5'd11, 1'b1, 1'b0, 3'b010);
        dmem_rdata = 32'h1234_5678;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clk);
            idle32();
            if (out_valid) got = 1'b1;
            else if (dmem_req) req_cycles++;
            dmem_ready = ready_last && (req_cycles == 4);
        end
        dmem_ready = 1'b0;
        tests++; if (got !== 1'b1 || req_cycles != 4) begin failed++;
            $display("FAIL to_len rdy=%b: done=%b req_cycles=%0d required 1 4", ready_last, got, req_cycles); end
        if (ready_last) begin
            tests++; if (out_bus_error !== 1'b0 || out_reg_write !== 1'b1 || out_result !== 32'h1234_5678) begin failed++;
                $display("FAIL to_ready: berr=%b rw=%b result=%h required 0 1 12345678", out_bus_error, out_reg_write, out_result); end
        end else begin
            tests++; if (out_bus_error !== 1'b1 || out_reg_write !== 1'b0 || out_misaligned !== 1'b0) begin failed++;
                $display("FAIL to_err: berr=%b rw=%b mis=%b required 1 0 0", out_bus_error, out_reg_write, out_misaligned); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_req();
        issue32(32'h0000_0300, 32'h0, 5'd12, 1'b1, 1'b0, 3'b010);
        @(negedge clk);
        idle32();
        tests++; if (dmem_req !== 1'b1) begin failed++;
            $display("FAIL mr_pre: req=%b required 1", dmem_req); end
        #2 reset = 1'b0;
        #1;
        tests++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin failed++;
            $display("FAIL mr_async: req=%b stall=%b required 0 0", dmem_req, stall); end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        tests++; if (out_valid !== 1'b0 || dmem_req !== 1'b0) begin failed++;
            $display("FAIL mr_drop: valid=%b req=%b required 0 0", out_valid, dmem_req); end
        issue32(32'h0000_0040, 32'h0, 5'd13, 1'b1, 1'b0, 3'b010);
        @(negedge clk);
        idle32();
        dmem_ready = 1'b1; dmem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        dmem_ready = 1'b0;
        tests++; if (out_valid !== 1'b1 || out_result !== 32'hCAFE_F00D || out_rd !== 5'd13) begin failed++;
            $display("FAIL mr_fresh: valid=%b result=%h rd=%0d required 1 cafef00d 13", out_valid, out_result, out_rd); end
        @(negedge clk);
    endtask

    task automatic test_xlen64(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] rdata,
                               input logic [7:0] exp_be, input logic [63:0] exp);
        w_in_valid = 1'b1; w_alu_result = a; w_mem_read = 1'b1; w_funct3 = f3; w_rd = 5'd20;
        @(negedge clk);
        w_in_valid = 1'b0; w_mem_read = 1'b0;
        tests++; if (w_dmem_req !== 1'b1 || w_dmem_be !== exp_be || w_dmem_addr !== 32'h8) begin failed++;
            $display("FAIL x64_req f3=%0d: req=%b be=%h addr=%h required 1 %h 8", f3, w_dmem_req, w_dmem_be, w_dmem_addr, exp_be); end
        w_dmem_ready = 1'b1; w_dmem_rdata = rdata;
        @(negedge clk);
        w_dmem_ready = 1'b0;
        tests++; if (w_out_valid !== 1'b1 || w_out_result !== exp || w_out_reg_write !== 1'b1) begin failed++;
            $display("FAIL x64_out f3=%0d: valid=%b result=%h rw=%b required 1 %h 1", f3, w_out_valid, w_out_result, w_out_reg_write, exp); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_passthru();
        test_load_byte(3'b000, 32'hFFFF_FF80);
        test_load_byte(3'b100, 32'h0000_0080);
        test_store_wait();
        test_misaligned("mis_lw", 32'h0000_0102, 3'b010, 1'b0);
        test_misaligned("ill_ld", 32'h0000_0100, 3'b011, 1'b0);
        test_misaligned("ill_lwu", 32'h0000_0100, 3'b110, 1'b0);
        test_misaligned("ill_sbu", 32'h0000_0100, 3'b100, 1'b1);
        test_timeout(1'b0);
        test_timeout(1'b1);
        test_reset_mid_req();
        test_xlen64(64'h8, 3'b011, 64'h8123_4567_89AB_CDEF, 8'hFF, 64'h8123_4567_89AB_CDEF);
        test_xlen64(64'hC, 3'b010, 64'h8000_0001_0000_0000, 8'hFF, 64'hFFFF_FFFF_8000_0001);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
